// File: rtl/fetch_pkg.sv
// Shared types and constants for the instruction-fetch front end.
package fetch_pkg;

  localparam int          XLEN       = 32;
  localparam int          ILEN_BYTES = 4;
  localparam logic [31:0] INSTR_NOP  = 32'h0000_0013;

  typedef struct packed {
    logic [XLEN-1:0] pc;
    logic [31:0]     instr;
    logic            misalign;
  } fetch_entry_t;

endpackage

// File: rtl/fetch_queue.sv
// Synchronous FIFO of fetch entries with flush; when empty the head shows the
// last dequeued entry so decode-facing outputs do not toggle needlessly.
module fetch_queue
  import fetch_pkg::*;
#(
  parameter int DEPTH = 2
) (
  input  logic                   clk,
  input  logic                   reset_n,
  input  logic                   push,
  input  logic                   pop,
  input  logic                   flush,
  input  fetch_entry_t           din,
  output fetch_entry_t           head,
  output logic                   valid,
  output logic [$clog2(DEPTH):0] count
);

  localparam int PW = $clog2(DEPTH);
  localparam int CW = PW + 1;

  fetch_entry_t   mem [DEPTH];
  fetch_entry_t   last_q;
  logic [PW-1:0]  wr_ptr, rd_ptr;

  assign valid = (count != '0);
  assign head  = valid ? mem[rd_ptr] : last_q;

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      count  <= '0;
      last_q <= '0;
    end else if (flush) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      count  <= '0;
    end else begin
      if (push) wr_ptr <= wr_ptr + PW'(1);
      if (pop) begin
        rd_ptr <= rd_ptr + PW'(1);
        last_q <= mem[rd_ptr];
      end
      case ({push, pop})
        2'b10:   count <= count + CW'(1);
        2'b01:   count <= count - CW'(1);
        default: count <= count;
      endcase
    end
  end

  // Storage needs no reset: it is only observed through valid/count.
  always_ff @(posedge clk) begin
    if (push && !flush) mem[wr_ptr] <= din;
  end

endmodule

// File: rtl/instr_fetch.sv
// PC generation and redirect handling in front of fetch_queue.
// Optional FETCH_MISALIGN_CHK_EN turns misaligned redirect targets into a fault entry plus halt.
module instr_fetch
  import fetch_pkg::*;
#(
  parameter logic [31:0] RESET_PC    = 32'h0000_0000,
  parameter int          QUEUE_DEPTH = 2
) (
  input  logic                         clk,
  input  logic                         reset_n,
  output logic [31:0]                  imem_pc,
  input  logic [31:0]                  imem_instr,
  input  logic                         redirect,
  input  logic [31:0]                  redirect_pc,
  output logic                         out_valid,
  input  logic                         out_ready,
  output logic [31:0]                  out_pc,
  output logic [31:0]                  out_instr,
  output logic                         out_misalign,
  output logic [$clog2(QUEUE_DEPTH):0] q_count
);

  localparam int CW = $clog2(QUEUE_DEPTH) + 1;

  logic [31:0]  pc_q;
  logic         halt_q, mis_pend_q;
  logic         push, pop, full;
  fetch_entry_t din, head;

  assign imem_pc = pc_q;
  assign pop     = out_valid & out_ready;
  assign full    = (q_count == CW'(QUEUE_DEPTH));
  assign push    = ~redirect & ~halt_q & (~full | pop);

  // A pending misalign fault replaces the fetched word with a NOP marker entry.
  always_comb begin
    din          = '0;
    din.pc       = pc_q;
    din.instr    = mis_pend_q ? INSTR_NOP : imem_instr;
    din.misalign = mis_pend_q;
  end

`ifdef FETCH_MISALIGN_CHK_EN
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      pc_q       <= RESET_PC;
      halt_q     <= 1'b0;
      mis_pend_q <= 1'b0;
    end else if (redirect) begin
      pc_q       <= redirect_pc;
      halt_q     <= 1'b0;
      mis_pend_q <= (redirect_pc[1:0] != 2'b00);
    end else if (push && mis_pend_q) begin
      halt_q     <= 1'b1;
      mis_pend_q <= 1'b0;
    end else if (push) begin
      pc_q <= pc_q + 32'(ILEN_BYTES);
    end
  end
`else
  assign halt_q     = 1'b0;
  assign mis_pend_q = 1'b0;

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n)      pc_q <= RESET_PC;
    else if (redirect) pc_q <= redirect_pc & ~32'h3;
    else if (push)     pc_q <= pc_q + 32'(ILEN_BYTES);
  end
`endif

  fetch_queue #(.DEPTH(QUEUE_DEPTH)) u_queue (
    .clk     (clk),
    .reset_n (reset_n),
    .push    (push),
    .pop     (pop),
    .flush   (redirect),
    .din     (din),
    .head    (head),
    .valid   (out_valid),
    .count   (q_count)
  );

  assign out_pc       = head.pc;
  assign out_instr    = head.instr;
  assign out_misalign = out_valid & head.misalign;

endmodule

// File: tb/tb_instr_fetch.sv
// Directed bench for instr_fetch; memory returns 32'hC0DE_0000 ^ pc.
module tb_instr_fetch;

  logic        clk = 1'b0;
  logic        reset_n;
  logic [31:0] imem_pc, imem_instr, redirect_pc, out_pc, out_instr;
  logic        redirect, out_valid, out_ready, out_misalign;
  logic [1:0]  q_count;

  int n_run  = 0;
  int n_fail = 0;

  always #5 clk = ~clk;

  assign imem_instr = 32'hC0DE_0000 ^ imem_pc;

  instr_fetch #(.RESET_PC(32'h0), .QUEUE_DEPTH(2)) dut (
    .clk          (clk),
    .reset_n      (reset_n),
    .imem_pc      (imem_pc),
    .imem_instr   (imem_instr),
    .redirect     (redirect),
    .redirect_pc  (redirect_pc),
    .out_valid    (out_valid),
    .out_ready    (out_ready),
    .out_pc       (out_pc),
    .out_instr    (out_instr),
    .out_misalign (out_misalign),
    .q_count      (q_count)
  );

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_run++;
    if (obs !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h, want %h", tag, obs, exp);
    end
  endtask

  task automatic step();
    @(negedge clk);
  endtask

  task automatic do_reset(input logic rdy);
    reset_n   = 1'b0;
    out_ready = rdy;
    redirect  = 1'b0;
    step();
    step();
    reset_n = 1'b1;
  endtask

  initial begin
    redirect_pc = '0;
    do_reset(1'b1);

    // 1: streaming with decode always ready
    reset_n = 1'b0;
    #1;
    chk("rst_valid", {31'b0, out_valid}, 32'd0);
    chk("rst_pc",    out_pc,            32'd0);
    chk("rst_instr", out_instr,         32'd0);
    chk("rst_cnt",   {30'b0, q_count},  32'd0);
    chk("rst_mis",   {31'b0, out_misalign}, 32'd0);
    chk("rst_imem",  imem_pc,           32'd0);
    step();
    reset_n = 1'b1;
    step();
    for (int k = 0; k < 8; k++) begin
      chk("s1_valid", {31'b0, out_valid}, 32'd1);
      chk("s1_pc",    out_pc,    32'(4 * k));
      chk("s1_instr", out_instr, 32'hC0DE_0000 ^ 32'(4 * k));
      chk("s1_cnt",   {30'b0, q_count}, 32'd1);
      step();
    end

    // 2: backpressure fills the queue and freezes the PC
    do_reset(1'b0);
    for (int k = 0; k < 5; k++) step();
    chk("s2_cnt",  {30'b0, q_count}, 32'd2);
    chk("s2_imem", imem_pc, 32'd8);
    chk("s2_head", out_pc,  32'd0);
    out_ready = 1'b1;
    for (int k = 0; k < 4; k++) begin
      chk("s2_pc",  out_pc, 32'(4 * k));
      chk("s2_cnt_full", {30'b0, q_count}, 32'd2);
      step();
    end

    // 3: redirect while full and popping
    redirect    = 1'b1;
    redirect_pc = 32'h14;
    step();
    redirect = 1'b0;
    chk("s3_valid", {31'b0, out_valid}, 32'd0);
    chk("s3_cnt",   {30'b0, q_count}, 32'd0);
    chk("s3_imem",  imem_pc, 32'h14);
    step();
    chk("s3_valid2", {31'b0, out_valid}, 32'd1);
    chk("s3_pc",     out_pc,    32'h14);
    chk("s3_instr",  out_instr, 32'hC0DE_0014);

    // 4: PC wraps from the top of the address space
    redirect    = 1'b1;
    redirect_pc = 32'hFFFF_FFFC;
    step();
    redirect = 1'b0;
    step();
    chk("s4_pc_top", out_pc, 32'hFFFF_FFFC);
    chk("s4_imem",   imem_pc, 32'h0);
    step();
    chk("s4_pc_wrap", out_pc, 32'h0);
    chk("s4_instr",   out_instr, 32'hC0DE_0000);

    // 5: misaligned redirect target
    redirect    = 1'b1;
    redirect_pc = 32'h6;
    step();
    redirect = 1'b0;
`ifdef FETCH_MISALIGN_CHK_EN
    chk("s5_imem", imem_pc, 32'h6);
    step();
    chk("s5_valid", {31'b0, out_valid}, 32'd1);
    chk("s5_pc",    out_pc,    32'h6);
    chk("s5_instr", out_instr, 32'h13);
    chk("s5_mis",   {31'b0, out_misalign}, 32'd1);
    for (int k = 0; k < 3; k++) step();
    chk("s5_halt_valid", {31'b0, out_valid}, 32'd0);
    chk("s5_halt_cnt",   {30'b0, q_count}, 32'd0);
    redirect    = 1'b1;
    redirect_pc = 32'h0;
    step();
    redirect = 1'b0;
    step();
    chk("s5_resume_pc",  out_pc, 32'h0);
    chk("s5_resume_mis", {31'b0, out_misalign}, 32'd0);
`else
    chk("s5_imem", imem_pc, 32'h4);
    step();
    chk("s5_valid", {31'b0, out_valid}, 32'd1);
    chk("s5_pc",    out_pc,    32'h4);
    chk("s5_instr", out_instr, 32'hC0DE_0004);
    chk("s5_mis",   {31'b0, out_misalign}, 32'd0);
    step();
    chk("s5_next_pc", out_pc, 32'h8);
`endif

    // 6: asynchronous reset with a full queue
    out_ready = 1'b0;
    for (int k = 0; k < 3; k++) step();
    chk("s6_full", {30'b0, q_count}, 32'd2);
    #2;
    reset_n = 1'b0;
    #1;
    chk("s6_valid", {31'b0, out_valid}, 32'd0);
    chk("s6_cnt",   {30'b0, q_count}, 32'd0);
    chk("s6_pc",    out_pc,    32'd0);
    chk("s6_instr", out_instr, 32'd0);
    chk("s6_imem",  imem_pc,   32'd0);
    step();
    reset_n   = 1'b1;
    out_ready = 1'b1;
    step();
    chk("s6_restart_pc",  out_pc, 32'd0);
    step();
    chk("s6_restart_pc2", out_pc, 32'd4);

    $display("[TB] %0d tests run, %0d failed", n_run, n_fail);
    $finish;
  end

endmodule
